// File: rtl/sym_spawn_scheduler.sv
// Per-level symbol spawn scheduler and answer counter; every output is registered (1 tick), with no backpressure.
// Define SYM_SPAWN_NOREPEAT_EN to nudge a spawn position off the previous spawn's position.
module sym_spawn_scheduler #(
    parameter int          MAX_COUNT = 99,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          NUM_POS   = 16
) (
    input  logic       Clk1Hz,
    input  logic       reset,
    input  logic       gamePeriod,
    input  logic       answerPeriod,
    input  logic       levelChng,
    input  logic [4:0] level,
    input  logic       btnInc,
    input  logic       btnDec,
    output logic       spawnValid,
    output logic [1:0] spawnSym,
    output logic [3:0] spawnPos,
    output logic [1:0] targetSym,
    output logic [6:0] trueCount,
    output logic [6:0] userCount,
    output logic [6:0] symCountDiff,
    output logic       diffValid
);

    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [6:0]  MAX_C    = 7'(MAX_COUNT);
    localparam logic [3:0]  POS_MASK = 4'(NUM_POS - 1);

    typedef enum logic [2:0] {IDLE, GAME, ANSWER, EVAL, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        spawn_valid_q, spawn_valid_d;
    logic [1:0]  spawn_sym_q, spawn_sym_d;
    logic [3:0]  spawn_pos_q, spawn_pos_d;
    logic [1:0]  target_sym_q, target_sym_d;
    logic [6:0]  true_cnt_q, true_cnt_d;
    logic [6:0]  user_cnt_q, user_cnt_d;
    logic [6:0]  diff_q, diff_d;
    logic        diff_valid_q, diff_valid_d;
`ifdef SYM_SPAWN_NOREPEAT_EN
    logic        prev_vld_q, prev_vld_d;
    logic [3:0]  prev_pos_q, prev_pos_d;
`endif

    logic [5:0]  thr;
    logic [3:0]  cand_pos;
    logic        enter_game;

    always_comb begin
        state_d       = state_q;
        lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
        spawn_valid_d = spawn_valid_q;
        spawn_sym_d   = spawn_sym_q;
        spawn_pos_d   = spawn_pos_q;
        target_sym_d  = target_sym_q;
        true_cnt_d    = true_cnt_q;
        user_cnt_d    = user_cnt_q;
        diff_d        = diff_q;
        diff_valid_d  = diff_valid_q;
        enter_game    = 1'b0;
        // Threshold is widened to 6 bits so high levels saturate rather than wrap
        thr = {1'b0, level} + 6'd4;
        if (thr > 6'd15) thr = 6'd15;
        cand_pos = lfsr_q[13:10] & POS_MASK;
`ifdef SYM_SPAWN_NOREPEAT_EN
        prev_vld_d = prev_vld_q;
        prev_pos_d = prev_pos_q;
        if (prev_vld_q && cand_pos == prev_pos_q) cand_pos = (cand_pos + 4'd1) & POS_MASK;
`endif

        unique case (state_q)
            IDLE: begin
                if (gamePeriod) enter_game = 1'b1;
            end
            GAME: begin
                if (gamePeriod) begin
                    if ({2'b00, lfsr_q[7:4]} < thr) begin
                        spawn_valid_d = 1'b1;
                        spawn_sym_d   = lfsr_q[9:8];
                        spawn_pos_d   = cand_pos;
`ifdef SYM_SPAWN_NOREPEAT_EN
                        prev_vld_d    = 1'b1;
                        prev_pos_d    = cand_pos;
`endif
                        if (lfsr_q[9:8] == target_sym_q && true_cnt_q < MAX_C)
                            true_cnt_d = true_cnt_q + 7'd1;
                    end else begin
                        spawn_valid_d = 1'b0;
                    end
                end else begin
                    spawn_valid_d = 1'b0;
                    state_d       = answerPeriod ? ANSWER : EVAL;
                end
            end
            ANSWER: begin
                if (answerPeriod) begin
                    if (btnInc && !btnDec && user_cnt_q < MAX_C)
                        user_cnt_d = user_cnt_q + 7'd1;
                    else if (btnDec && !btnInc && user_cnt_q != 7'd0)
                        user_cnt_d = user_cnt_q - 7'd1;
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                diff_d       = (true_cnt_q >= user_cnt_q) ? (true_cnt_q - user_cnt_q)
                                                          : (user_cnt_q - true_cnt_q);
                diff_valid_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (levelChng) begin
                    diff_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (gamePeriod) begin
                    enter_game = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh level starts from zero counts; the entry edge never spawns
        if (enter_game) begin
            state_d      = GAME;
            true_cnt_d   = 7'd0;
            user_cnt_d   = 7'd0;
            diff_d       = 7'd0;
            diff_valid_d = 1'b0;
            target_sym_d = lfsr_q[1:0];
`ifdef SYM_SPAWN_NOREPEAT_EN
            prev_vld_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge Clk1Hz or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            spawn_valid_q <= 1'b0;
            spawn_sym_q   <= 2'd0;
            spawn_pos_q   <= 4'd0;
            target_sym_q  <= 2'd0;
            true_cnt_q    <= 7'd0;
            user_cnt_q    <= 7'd0;
            diff_q        <= 7'd0;
            diff_valid_q  <= 1'b0;
`ifdef SYM_SPAWN_NOREPEAT_EN
            prev_vld_q    <= 1'b0;
            prev_pos_q    <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_sym_q   <= spawn_sym_d;
            spawn_pos_q   <= spawn_pos_d;
            target_sym_q  <= target_sym_d;
            true_cnt_q    <= true_cnt_d;
            user_cnt_q    <= user_cnt_d;
            diff_q        <= diff_d;
            diff_valid_q  <= diff_valid_d;
`ifdef SYM_SPAWN_NOREPEAT_EN
            prev_vld_q    <= prev_vld_d;
            prev_pos_q    <= prev_pos_d;
`endif
        end
    end

    assign spawnValid   = spawn_valid_q;
    assign spawnSym     = spawn_sym_q;
    assign spawnPos     = spawn_pos_q;
    assign targetSym    = target_sym_q;
    assign trueCount    = true_cnt_q;
    assign userCount    = user_cnt_q;
    assign symCountDiff = diff_q;
    assign diffValid    = diff_valid_q;

endmodule
